// File: rtl/eth_rx_seq_pkg.sv
// Shared types, constants and helpers for the Ethernet RX packet sequencer.
package eth_rx_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDesc,
    StFwd,
    StDrain
  } state_e;

  localparam int unsigned ETH_MIN_PACKET_LENGTH = 64;
  localparam int unsigned ETH_MAX_PACKET_LENGTH = 1522;

  // Widest tkeep the popcount helper accepts; narrower buses are zero-extended.
  localparam int unsigned KEEP_MAX_WIDTH = 128;

  // A single-lane bus carries no byte enables, so every beat is one full byte.
  function automatic int unsigned keep_popcount(input logic [KEEP_MAX_WIDTH-1:0] keep,
                                                input int unsigned width);
    int unsigned n;
    n = 0;
    if (width <= 1) begin
      return 1;
    end
    for (int unsigned i = 0; i < KEEP_MAX_WIDTH; i++) begin
      if (i < width && keep[i]) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_rx_pkt_sequencer.sv
// Pops one length entry per frame, filters on length, then either issues a descriptor and
// forwards the frame (checking its byte count) or drains it silently.
module eth_rx_pkt_sequencer
  import eth_rx_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned DESC_WIDTH = LEN_WIDTH + 1
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst_n,
  input  logic [LEN_WIDTH-1:0]  s_len_tdata,
  input  logic                  s_len_tvalid,
  output logic                  s_len_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DESC_WIDTH-1:0] m_desc_tdata,
  output logic                  m_desc_tvalid,
  input  logic                  m_desc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  enable,
  input  logic [DESC_WIDTH-1:0] cfg_min_len,
  input  logic [DESC_WIDTH-1:0] cfg_max_len,
  output logic                  stat_mismatch,
  output logic [31:0]           stat_fwd_count,
  output logic [15:0]           stat_drop_count,
  output logic [15:0]           stat_mismatch_count
);

  // One spare bit so an overlong frame cannot wrap back onto the expected length.
  localparam int unsigned CntWidth = DESC_WIDTH + 1;

  state_e                state_q, state_d;
  logic [DESC_WIDTH-1:0] exp_q, exp_d, exp_new;
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_sum, beat_bytes;
  logic                  length_bad, mismatch_evt, fwd_done, drop_done;
  logic                  stat_mismatch_q;
  logic [31:0]           fwd_count_q;
  logic [15:0]           drop_count_q, mismatch_count_q;

  assign exp_new    = DESC_WIDTH'(s_len_tdata) + DESC_WIDTH'(1);
  assign beat_bytes = CntWidth'(keep_popcount(KEEP_MAX_WIDTH'(s_axis_tkeep), KEEP_WIDTH));
  assign cnt_sum    = cnt_q + beat_bytes;
  assign length_bad = cnt_sum != {1'b0, exp_q};

  assign m_axis_tdata        = s_axis_tdata;
  assign m_axis_tkeep        = s_axis_tkeep;
  assign m_axis_tlast        = s_axis_tlast;
  assign m_desc_tdata        = exp_q;
  assign stat_mismatch       = stat_mismatch_q;
  assign stat_fwd_count      = fwd_count_q;
  assign stat_drop_count     = drop_count_q;
  assign stat_mismatch_count = mismatch_count_q;

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    cnt_d         = cnt_q;
    s_len_tready  = 1'b0;
    s_axis_tready = 1'b0;
    m_desc_tvalid = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tuser  = s_axis_tuser;
    mismatch_evt  = 1'b0;
    fwd_done      = 1'b0;
    drop_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_len_tready = enable;
        if (enable && s_len_tvalid) begin
          exp_d   = exp_new;
          state_d = (exp_new >= cfg_min_len && exp_new <= cfg_max_len) ? StDesc : StDrain;
        end
      end
      StDesc: begin
        m_desc_tvalid = 1'b1;
        if (m_desc_tready) begin
          cnt_d   = '0;
          state_d = StFwd;
        end
      end
      StFwd: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (s_axis_tlast && length_bad) begin
          m_axis_tuser = 1'b1;
        end
        if (s_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_sum;
          if (s_axis_tlast) begin
            mismatch_evt = length_bad;
            fwd_done     = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      StDrain: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q          <= StIdle;
      exp_q            <= '0;
      cnt_q            <= '0;
      stat_mismatch_q  <= 1'b0;
      fwd_count_q      <= '0;
      drop_count_q     <= '0;
      mismatch_count_q <= '0;
    end else begin
      state_q         <= state_d;
      exp_q           <= exp_d;
      cnt_q           <= cnt_d;
      stat_mismatch_q <= mismatch_evt;
      if (fwd_done) begin
        fwd_count_q <= fwd_count_q + 32'd1;
      end
      if (drop_done) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
      if (mismatch_evt) begin
        mismatch_count_q <= mismatch_count_q + 16'd1;
      end
    end
  end

endmodule
